// File: rtl/board_pkg.sv
// board_pkg: shared widths, cell encoding, result codes, FSM states and the
// move request payload used by the board move engine and its cell indexer.
package board_pkg;

    localparam int unsigned CELL_W      = 3;
    localparam int unsigned BOARD_CELLS = 64;
    localparam int unsigned BOARD_W     = BOARD_CELLS * CELL_W;
    localparam int unsigned COORD_W     = 4;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned OFF_W       = 8;
    localparam int unsigned ERR_W       = 2;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 3'b000;

    typedef enum logic [ERR_W-1:0] {
        ERR_OK        = 2'd0,
        ERR_BAD_COORD = 2'd1,
        ERR_SRC_EMPTY = 2'd2,
        ERR_SAME_CELL = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
    } move_req_t;

    // Bit offset of a cell inside the board vector: idx*3 = 2*idx + idx.
    function automatic logic [OFF_W-1:0] cell_off(input logic [IDX_W-1:0] idx);
        return OFF_W'({idx, 1'b0}) + OFF_W'(idx);
    endfunction

endpackage

// File: rtl/board_move_engine_if.sv
// board_move_engine_if: move request handshake and completion report.
//   master: drives move_valid and src/dst coordinates, observes ready/done/result.
//   slave : the engine; drives move_ready, done, done_err, captured.
interface board_move_engine_if;
    import board_pkg::*;

    logic                move_valid;
    logic                move_ready;
    logic [COORD_W-1:0]  src_x;
    logic [COORD_W-1:0]  src_y;
    logic [COORD_W-1:0]  dst_x;
    logic [COORD_W-1:0]  dst_y;
    logic                done;
    logic [ERR_W-1:0]    done_err;
    logic [CELL_W-1:0]   captured;

    modport master (
        output move_valid, src_x, src_y, dst_x, dst_y,
        input  move_ready, done, done_err, captured
    );

    modport slave (
        input  move_valid, src_x, src_y, dst_x, dst_y,
        output move_ready, done, done_err, captured
    );

endinterface

// File: rtl/board_cell_index.sv
// board_cell_index: maps 1-based board coordinates to a linear cell index.
//   x, y     in  : column / row, legal 1..8
//   idx      out : (y-1)*8 + (x-1), meaningful only when in_range
//   in_range out : both coordinates within 1..8
module board_cell_index
    import board_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [IDX_W-1:0]   idx,
    output logic               in_range
);

    logic [COORD_W-1:0] xm1;
    logic [COORD_W-1:0] ym1;

    always_comb begin
        xm1 = x - COORD_W'(1);
        ym1 = y - COORD_W'(1);
        idx = {ym1[2:0], xm1[2:0]};
        // coord-1 lands in 0..7 exactly for 1..8; 0 wraps to 15 and 9..15 map to 8..14
        in_range = !xm1[3] && !ym1[3];
    end

endmodule

// File: rtl/board_move_engine.sv
// board_move_engine: owns the 64-cell board register and applies one validated
// single-piece move per handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   mv           : request handshake + completion report (slave side)
//   board_state  : registered board, cell (x,y) at [((y-1)*8+(x-1))*3 +: 3]
//   move_count   : committed move counter, wraps
module board_move_engine
    import board_pkg::*;
#(
    parameter logic [BOARD_W-1:0] INIT_BOARD = '0,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    board_move_engine_if.slave    mv,
    output logic [BOARD_W-1:0]    board_state,
    output logic [CNT_W-1:0]      move_count
);

    state_e              state_q, state_d;
    move_req_t           req_q, req_d;
    err_e                err_q, err_d;
    logic [CELL_W-1:0]   cap_q, cap_d;
    logic [BOARD_W-1:0]  board_q, board_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    err_e                done_err_q, done_err_d;
    logic [CELL_W-1:0]   captured_q, captured_d;
    logic                ready_q, ready_d;

    logic [IDX_W-1:0]    src_idx, dst_idx;
    logic                src_ok, dst_ok;
    logic [OFF_W-1:0]    src_off, dst_off;
    logic [CELL_W-1:0]   src_cell, dst_cell;

    board_cell_index u_src_index (
        .x        (req_q.src_x),
        .y        (req_q.src_y),
        .idx      (src_idx),
        .in_range (src_ok)
    );

    board_cell_index u_dst_index (
        .x        (req_q.dst_x),
        .y        (req_q.dst_y),
        .idx      (dst_idx),
        .in_range (dst_ok)
    );

    // Cell reads from the latched request; board is stable from CHECK through WRITE.
    always_comb begin
        src_off  = cell_off(src_idx);
        dst_off  = cell_off(dst_idx);
        src_cell = board_q[src_off +: CELL_W];
        dst_cell = board_q[dst_off +: CELL_W];
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        err_d      = err_q;
        cap_d      = cap_q;
        board_d    = board_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        done_err_d = done_err_q;
        captured_d = captured_q;

        case (state_q)
            ST_IDLE: begin
                if (mv.move_valid) begin
                    req_d.src_x = mv.src_x;
                    req_d.src_y = mv.src_y;
                    req_d.dst_x = mv.dst_x;
                    req_d.dst_y = mv.dst_y;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!src_ok || !dst_ok) begin
                    err_d = ERR_BAD_COORD;
                end else if (src_idx == dst_idx) begin
                    err_d = ERR_SAME_CELL;
                end else if (src_cell == CELL_EMPTY) begin
                    err_d = ERR_SRC_EMPTY;
                end else begin
                    err_d = ERR_OK;
                end
                cap_d   = CELL_EMPTY;
                state_d = (err_d == ERR_OK) ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                // src and dst differ here, so the two writes never overlap
                board_d[src_off +: CELL_W] = CELL_EMPTY;
                board_d[dst_off +: CELL_W] = src_cell;
                cap_d   = dst_cell;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // result is published together with done, so it stays stable between reports
                done_d     = 1'b1;
                done_err_d = err_q;
                captured_d = cap_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            err_q      <= ERR_OK;
            cap_q      <= CELL_EMPTY;
            board_q    <= INIT_BOARD;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            done_err_q <= ERR_OK;
            captured_q <= CELL_EMPTY;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
            board_q    <= board_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
            captured_q <= captured_d;
            ready_q    <= ready_d;
        end
    end

    assign mv.move_ready = ready_q;
    assign mv.done       = done_q;
    assign mv.done_err   = done_err_q;
    assign mv.captured   = captured_q;
    assign board_state   = board_q;
    assign move_count    = cnt_q;

endmodule
